stream_muxn: RTL
================

Name: stream_muxn

Overview:
- N-input, parametrised-width stream multiplexer with valid/ready handshakes on every input and on the output.
- The output path is registered.
- Selection mode is set at build time:
  - MODE 0: external select, the direct sequential successor of the plain 2:1 data mux.
  - MODE 1: round-robin arbitration with packet locking.
- Sits between multiple producer streams and a single shared consumer, e.g. a shared datapath or an output port.

Parameters:
- WIDTH, 16, data width per channel.
- N_INPUTS, 4, number of input channels, ≥2.
- MODE, 0, 0 = external select via i_sel; 1 = round-robin with packet lock.
- SEL_W, $clog2(N_INPUTS), derived select/source-index width; not overridden.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_data  input  N_INPUTS*WIDTH  flattened channel data; channel k occupies [k*WIDTH +: WIDTH].
- i_valid  input  N_INPUTS  per-channel valid.
- i_last  input  N_INPUTS  per-channel end-of-packet marker.
- o_ready  output  N_INPUTS  per-channel ready.
- i_sel  input  SEL_W  channel select; used only in MODE 0.
- o_data  output  WIDTH  registered output data.
- o_valid  output  1  output valid.
- o_last  output  1  registered end-of-packet marker.
- o_src  output  SEL_W  index of the channel that supplied the current output word.
- i_ready  input  1  downstream ready.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous, active-high.
- Reset values:
  - o_valid=0, o_data=0, o_last=0, o_src=0.
  - Round-robin pointer ptr=N_INPUTS-1, so channel 0 has first priority after reset.
  - Lock flag=0.
- Reset mid-packet: the lock is dropped and any registered word is discarded (o_valid=0 next cycle). o_ready is forced to 0 while i_rst=1.
- Output register:
  - can_accept = !o_valid || i_ready.
  - An input transfer occurs on channel k when i_valid[k] && o_ready[k] at a rising edge.
  - On transfer: o_data, o_last, o_src take that channel's word, last bit and index; o_valid=1.
  - If i_ready && o_valid and no new transfer: o_valid=0.
  - o_data, o_last and o_src hold while o_valid && !i_ready.
- Throughput and latency: latency 1 cycle. Full throughput of one word per cycle when i_ready is held high.
- o_ready decode:
  - At most one o_ready bit is high per cycle.
  - o_ready[k] = grant[k] && can_accept.
  - o_ready depends combinationally on i_ready and on grant. In MODE 1, grant also depends on i_valid.
- MODE 0:
  - grant[k] = (i_sel == k), evaluated each cycle.
  - i_sel ≥ N_INPUTS (non-power-of-2 N): no grant, all o_ready=0, no transfer.
  - i_last is passed through to o_last but does not otherwise affect behaviour.
- MODE 1, unlocked:
  - Grant goes to the first channel with i_valid set, searching ptr+1, ptr+2, … modulo N_INPUTS.
  - No valid channel: no grant.
- MODE 1, locking:
  - A transfer with i_last=0 sets lock and freezes the grant on that channel.
  - While locked, grant stays on the locked channel even if it deasserts i_valid. Other channels are stalled.
  - A transfer with i_last=1 clears lock and sets ptr to the granted index.
  - A single-word packet (i_last=1) never locks and advances ptr immediately.
- Wrap-around: the pointer search wraps from N_INPUTS-1 to 0.
- Simultaneous events: output drain (i_ready) and new input transfer in the same cycle are both honoured; o_valid stays 1 with the new word.

Test Plan:
- Reset then idle: hold i_rst 2 cycles, all inputs 0 -> o_valid=0, o_data=0, o_src=0, o_ready=0 during reset.
- MODE 0 select:
  - Setup: N=4, WIDTH=16, i_data ch0..3=16'h1111/2222/3333/4444, all valid, i_sel=2, i_ready=1.
  - Response: o_ready=4'b0100; next cycle o_data=16'h3333, o_src=2.
  - Then set i_sel=0 -> following cycle o_data=16'h1111.
- Backpressure:
  - Stimulus: i_ready=0 after first transfer for 3 cycles.
  - Response: o_data holds, o_valid=1, all o_ready=0.
  - i_ready=1 -> next word accepted same cycle, no word lost or duplicated (scoreboard).
- MODE 1 round-robin:
  - Stimulus: all 4 channels valid with single-word packets (i_last=1), i_ready=1.
  - Response: o_src sequence 0,1,2,3,0,… one word per cycle.
- MODE 1 packet lock:
  - Stimulus: ch1 sends a 3-word packet (last on word 3) while ch0 and ch2 are valid; ch1 drops valid for 1 cycle mid-packet.
  - Response: o_src=1 for all 3 words; no ch0/ch2 transfer until ch1 last; then grant goes to ch2.
- Reset mid-packet: assert i_rst while locked on ch3 with o_valid=1 -> next cycle o_valid=0, lock cleared; after release ch0 is granted first.

Source files
------------

// File: rtl/stream_muxn.sv
// N-input valid/ready stream multiplexer with a registered output stage.
// MODE 0 selects the channel from i_sel; MODE 1 arbitrates round-robin and locks a packet's channel until its last word.
module stream_muxn #(
  parameter int WIDTH    = 16,
  parameter int N_INPUTS = 4,
  parameter int MODE     = 0,
  parameter int SEL_W    = $clog2(N_INPUTS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_INPUTS*WIDTH-1:0] i_data,
  input  logic [N_INPUTS-1:0]       i_valid,
  input  logic [N_INPUTS-1:0]       i_last,
  output logic [N_INPUTS-1:0]       o_ready,
  input  logic [SEL_W-1:0]          i_sel,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_valid,
  output logic                      o_last,
  output logic [SEL_W-1:0]          o_src,
  input  logic                      i_ready
);

  logic [N_INPUTS-1:0] grant;
  logic [SEL_W-1:0]    gnt_idx;
  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    lock_idx;
  logic                locked;
  logic                found;
  int                  idx;
  logic                can_accept;
  logic                xfer;
  logic [WIDTH-1:0]    sel_data;
  logic                sel_last;

  // Grant selection. The search starts one past the last packet's source so
  // every channel gets a turn; a locked packet keeps the grant even when idle.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (MODE == 0) begin
      for (int k = 0; k < N_INPUTS; k++) begin
        if (i_sel == SEL_W'(k)) begin
          grant[k] = 1'b1;
          gnt_idx  = SEL_W'(k);
        end
      end
    end else if (locked) begin
      grant[lock_idx] = 1'b1;
      gnt_idx         = lock_idx;
    end else begin
      for (int off = 1; off <= N_INPUTS; off++) begin
        idx = (int'(ptr) + off) % N_INPUTS;
        if (!found && i_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (grant[k]) begin
        sel_data = i_data[k*WIDTH +: WIDTH];
        sel_last = i_last[k];
      end
    end
  end

  assign can_accept = !o_valid || i_ready;
  assign o_ready    = i_rst ? '0 : (grant & {N_INPUTS{can_accept}});
  assign xfer       = |(o_ready & i_valid);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_last   <= 1'b0;
      o_src    <= '0;
      ptr      <= SEL_W'(N_INPUTS - 1);
      locked   <= 1'b0;
      lock_idx <= '0;
    end else begin
      if (xfer) begin
        o_valid <= 1'b1;
        o_data  <= sel_data;
        o_last  <= sel_last;
        o_src   <= gnt_idx;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      if (MODE == 1 && xfer) begin
        if (sel_last) begin
          locked <= 1'b0;
          ptr    <= gnt_idx;
        end else begin
          locked   <= 1'b1;
          lock_idx <= gnt_idx;
        end
      end
    end
  end

endmodule
